// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the sequential multiply/divide unit.
//   OP_*       : operation encodings presented on mdu_seq.op
//   state_t    : sequencer states (IDLE, CALC, FIX)
//   ITER       : radix-2 iterations per operation for the 32-bit MIPS unit
//   DIV0_LO    : LO value produced by a divide by zero
//   op_is_signed(): true for MULT and DIV, which work on magnitudes plus signs
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int ITER = 32;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step -- one combinational restoring-division iteration.
// Ports:
//   rem_i  partial remainder before this step
//   dvd_i  dividend bits still to be consumed (MSB first); quotient bits
//          collect in the LSBs as the register shifts left
//   dsr_i  divisor magnitude
//   rem_o  partial remainder after this step
//   dvd_o  dvd_i shifted left by one with the new quotient bit in bit 0
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shifted = {rem_i, dvd_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_i};
  // While rem_i < dsr_i the trial difference fits in WIDTH bits exactly when
  // it is non-negative, so bit WIDTH acts as the borrow. With a zero divisor
  // the borrow can be wrong, but then diff == shifted and the remainder path
  // is identical; the quotient is replaced by the divide-by-zero constant.
  assign fits    = ~diff[WIDTH];

  assign rem_o = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_o = {dvd_i[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq -- iterative radix-2 multiply/divide unit producing MIPS HI/LO.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         launch request (sampled in IDLE) and operation select
//   a, b              rs / rt operands
//   hi_we, lo_we      MTHI / MTLO write enables (IDLE only), data on wdata
//   hi, lo            registered HI / LO
//   busy              operation in progress (CALC or FIX)
//   done              one-cycle pulse in the cycle after HI/LO are written
// Build option: define MDU_DIV_EN to include the divide datapath. Without it,
// DIV/DIVU still run the full 33-cycle sequence but leave HI/LO untouched.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  // One iteration per operand bit; ITER covers the 32-bit MIPS build.
  localparam int N_ITER = (WIDTH == 32) ? ITER : WIDTH;
  localparam int CW     = $clog2(N_ITER);
  localparam logic [CW-1:0] LAST = CW'(N_ITER - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Shared working register. Multiply: {partial product high, multiplier
  // being shifted out}. Divide: {partial remainder, dividend -> quotient}.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_neg;

  assign sign_a = op_is_signed(op) & a[WIDTH-1];
  assign sign_b = op_is_signed(op) & b[WIDTH-1];
  assign abs_a  = sign_a ? -a : a;
  assign abs_b  = sign_b ? -b : b;

  // Right-shifting shift-add: add the multiplicand into the top half when
  // the current multiplier LSB is set, keeping the carry in the shifted word.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign prod_neg = -prod_q;

`ifdef MDU_DIV_EN
  localparam logic [WIDTH-1:0] DZ_LO = WIDTH'(DIV0_LO);

  logic             dz_q, dz_d;
  logic [WIDTH-1:0] div_rem, div_dvd;
  logic [WIDTH-1:0] rem_fix, quot_fix;

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i(prod_q[2*WIDTH-1:WIDTH]),
    .dvd_i(prod_q[WIDTH-1:0]),
    .dsr_i(opnd_q),
    .rem_o(div_rem),
    .dvd_o(div_dvd)
  );

  // Remainder follows the dividend sign, quotient truncates toward zero.
  // The -2^31 / -1 case wraps naturally back to 0x80000000.
  assign rem_fix  = sa_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
  assign quot_fix = (sa_q ^ sb_q) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    dz_d     = dz_q;
`endif

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = CALC;
          count_d  = '0;
          is_div_d = op[1];
          sa_d     = sign_a;
          sb_d     = sign_b;
          if (op[1]) begin
            prod_d = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            prod_d = {{WIDTH{1'b0}}, abs_b};
            opnd_d = abs_a;
          end
`ifdef MDU_DIV_EN
          dz_d = (b == '0);
`endif
        end
      end

      CALC: begin
        if (!is_div_q) begin
          prod_d = mul_next;
        end
`ifdef MDU_DIV_EN
        else begin
          prod_d = {div_rem, div_dvd};
        end
`endif
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : prod_q;
        end
`ifdef MDU_DIV_EN
        else begin
          hi_d = rem_fix;
          lo_d = dz_q ? DZ_LO : quot_fix;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq -- directed self-checking bench for mdu_seq.
// Expected values are hand-computed constants. Divide expectations follow
// the MDU_DIV_EN build option in the same way as the design.
module tb_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation from IDLE and run until done (bounded). Optionally
  // pokes start/hi_we/lo_we (mask bits 2/1/0) for one cycle at poke_cyc and
  // returns hi/lo as seen right after that poke. Returns in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_cyc, input logic [2:0] poke,
                        output int busy_cnt, output int lat,
                        output logic [31:0] hi_p, output logic [31:0] lo_p);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;  // operands must already be latched
    busy_cnt = 0; lat = 0; hi_p = hi; lo_p = lo;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lat == poke_cyc) begin
        start = poke[2]; hi_we = poke[1]; lo_we = poke[0];
        op = 2'b00; a = 32'h11; b = 32'h22; wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == poke_cyc + 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        hi_p = hi; lo_p = lo;
      end
    end
  endtask

  task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
    hi_we = 1'b1; lo_we = 1'b1; wdata = hv; lo_we = 1'b0;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = lv;
    @(posedge clk); #1;
    lo_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (hi !== 32'h0)  begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    if (lo !== 32'h0)  begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
  endtask

  task automatic test_multu();
    int bc, lat; logic [31:0] hp, lp;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'b000, bc, lat, hp, lp);
    $display("MULTU ffffffff*ffffffff: hi=%h lo=%h busy_cycles=%0d latency=%0d", hi, lo, bc, lat);
    checks += 4;
    if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=%h", hi, 32'hFFFF_FFFE); end
    if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=%h", lo, 32'h1); end
    if (bc != 33)  begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    if (lat != 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", lat); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mult();
    int bc, lat; logic [31:0] hp, lp;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, 3'b000, bc, lat, hp, lp);
    $display("MULT -3*7: hi=%h lo=%h latency=%0d", hi, lo, lat);
    checks += 3;
    if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
    if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h exp=%h", lo, 32'hFFFF_FFEB); end
    if (lat != 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    // {op, a, b, exp_hi, exp_lo}
    logic [1:0]  v_op [5];
    logic [31:0] v_a  [5];
    logic [31:0] v_b  [5];
    logic [31:0] v_hi [5];
    logic [31:0] v_lo [5];
    int bc, lat; logic [31:0] hp, lp;
    v_op[0] = 2'b10; v_a[0] = 32'hFFFF_FFF9; v_b[0] = 32'd2;        v_hi[0] = 32'hFFFF_FFFF; v_lo[0] = 32'hFFFF_FFFD;
    v_op[1] = 2'b11; v_a[1] = 32'd100;       v_b[1] = 32'd7;        v_hi[1] = 32'd2;         v_lo[1] = 32'd14;
    v_op[2] = 2'b10; v_a[2] = 32'h8000_0000; v_b[2] = 32'hFFFF_FFFF; v_hi[2] = 32'd0;        v_lo[2] = 32'h8000_0000;
    v_op[3] = 2'b11; v_a[3] = 32'd5;         v_b[3] = 32'd0;        v_hi[3] = 32'd5;         v_lo[3] = 32'hFFFF_FFFF;
    v_op[4] = 2'b10; v_a[4] = 32'hFFFF_FFF9; v_b[4] = 32'd0;        v_hi[4] = 32'hFFFF_FFF9; v_lo[4] = 32'hFFFF_FFFF;
`ifndef MDU_DIV_EN
    // Divide datapath absent: HI/LO must keep what MTHI/MTLO put there.
    for (int i = 0; i < 5; i++) begin
      v_hi[i] = 32'h0000_CAFE;
      v_lo[i] = 32'h0000_BEEF;
    end
    mt_write(32'h0000_CAFE, 32'h0000_BEEF);
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], -1, 3'b000, bc, lat, hp, lp);
      $display("DIV op=%b a=%h b=%h: hi=%h lo=%h latency=%0d", v_op[i], v_a[i], v_b[i], hi, lo, lat);
      checks += 3;
      if (hi !== v_hi[i]) begin failures++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, v_hi[i]); end
      if (lo !== v_lo[i]) begin failures++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, v_lo[i]); end
      if (lat != 33) begin failures++; $display("FAIL div%0d_latency got=%0d exp=33", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mt();
    mt_write(32'h0000_1234, 32'h0000_5678);
    $display("MTHI/MTLO: hi=%h lo=%h", hi, lo);
    checks += 2;
    if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi got=%h exp=%h", hi, 32'h1234); end
    if (lo !== 32'h0000_5678) begin failures++; $display("FAIL mtlo got=%h exp=%h", lo, 32'h5678); end
  endtask

  task automatic test_busy_ignore();
    int bc, lat; logic [31:0] hp, lp;
    mt_write(32'h0000_AAAA, 32'h0000_5555);
    run_op(2'b01, 32'd6, 32'd7, 5, 3'b011, bc, lat, hp, lp);
    $display("MT during busy: hi_mid=%h lo_mid=%h hi=%h lo=%h", hp, lp, hi, lo);
    checks += 4;
    if (hp !== 32'h0000_AAAA) begin failures++; $display("FAIL busy_mthi got=%h exp=%h", hp, 32'hAAAA); end
    if (lp !== 32'h0000_5555) begin failures++; $display("FAIL busy_mtlo got=%h exp=%h", lp, 32'h5555); end
    if (hi !== 32'd0)  begin failures++; $display("FAIL busy_mt_hi got=%h exp=0", hi); end
    if (lo !== 32'd42) begin failures++; $display("FAIL busy_mt_lo got=%h exp=%h", lo, 32'd42); end
    @(posedge clk); #1;
    run_op(2'b01, 32'd3, 32'd5, 10, 3'b100, bc, lat, hp, lp);
    $display("start during busy: hi=%h lo=%h busy_cycles=%0d latency=%0d", hi, lo, bc, lat);
    checks += 4;
    if (hi !== 32'd0)  begin failures++; $display("FAIL busy_start_hi got=%h exp=0", hi); end
    if (lo !== 32'd15) begin failures++; $display("FAIL busy_start_lo got=%h exp=%h", lo, 32'd15); end
    if (bc != 33)  begin failures++; $display("FAIL busy_start_cycles got=%0d exp=33", bc); end
    if (lat != 33) begin failures++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_relaunch got=%b exp=0", busy); end
  endtask

  task automatic test_same_cycle();
    int n;
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_7777;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    $display("start+MT same cycle: hi=%h lo=%h busy=%b", hi, lo, busy);
    checks += 3;
    if (hi !== 32'h0000_7777) begin failures++; $display("FAIL same_mthi got=%h exp=%h", hi, 32'h7777); end
    if (lo !== 32'h0000_7777) begin failures++; $display("FAIL same_mtlo got=%h exp=%h", lo, 32'h7777); end
    if (busy !== 1'b1) begin failures++; $display("FAIL same_busy got=%b exp=1", busy); end
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    $display("start+MT result: hi=%h lo=%h latency=%0d", hi, lo, n);
    checks += 3;
    if (n != 33) begin failures++; $display("FAIL same_latency got=%0d exp=33", n); end
    if (hi !== 32'd0)  begin failures++; $display("FAIL same_hi got=%h exp=0", hi); end
    if (lo !== 32'd81) begin failures++; $display("FAIL same_lo got=%h exp=%h", lo, 32'd81); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int bc, lat; logic [31:0] hp, lp;
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    checks += 3;
    if (hi !== 32'd0)  begin failures++; $display("FAIL midrst_hi got=%h exp=0", hi); end
    if (lo !== 32'd0)  begin failures++; $display("FAIL midrst_lo got=%h exp=0", lo); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b01, 32'd6, 32'd7, -1, 3'b000, bc, lat, hp, lp);
    $display("after reset MULTU 6*7: hi=%h lo=%h latency=%0d", hi, lo, lat);
    checks += 3;
    if (hi !== 32'd0)  begin failures++; $display("FAIL postrst_hi got=%h exp=0", hi); end
    if (lo !== 32'd42) begin failures++; $display("FAIL postrst_lo got=%h exp=%h", lo, 32'd42); end
    if (lat != 33) begin failures++; $display("FAIL postrst_latency got=%0d exp=33", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int bc, lat; logic [31:0] hp, lp;
    run_op(2'b01, 32'd11, 32'd13, -1, 3'b000, bc, lat, hp, lp);
    checks++;
    if (lo !== 32'd143) begin failures++; $display("FAIL b2b_first_lo got=%h exp=%h", lo, 32'd143); end
    // Launch straight from the done cycle.
    run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFB, -1, 3'b000, bc, lat, hp, lp);
    $display("back-to-back MULT -2*-5: hi=%h lo=%h busy_cycles=%0d latency=%0d", hi, lo, bc, lat);
    checks += 4;
    if (hi !== 32'd0)  begin failures++; $display("FAIL b2b_hi got=%h exp=0", hi); end
    if (lo !== 32'd10) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", lo, 32'd10); end
    if (bc != 33)  begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=33", bc); end
    if (lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_mt();
    test_busy_ignore();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Sequential multiply/divide unit that produces the MIPS HI/LO register pair for MULT, MULTU, DIV and DIVU. It sits in the execute stage, beside the ALU. Its hi/lo outputs feed the 32-bit 2:1 result mux that drives MFHI/MFLO data toward writeback. The core logic of each operation is iterative and radix-2, one bit per cycle. A busy/done handshake lets the pipeline control stall.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported for MIPS, and other values are for unit test only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand, the multiplicand or dividend.
- b  input  WIDTH  rt operand, the multiplier or divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO receive a result.

## Operation
- The clock is clk and the reset is rst_n; rst_n is asynchronous and active-low. The block uses this single clock only.
- States are IDLE, CALC and FIX.
  - IDLE → CALC: on start=1. At that edge, latch op, the operand magnitudes, the sign flags, and set count=0.
  - CALC → FIX: when count reaches 31, i.e. after 32 iteration cycles.
  - FIX → IDLE: always, after one cycle.
- Signed ops (MULT, DIV) use the absolute values of a and b. The result sign is then applied in FIX.
- MULT/MULTU:
  - Shift-add into a 64-bit accumulator.
  - In FIX, the accumulator is negated if sign(a) XOR sign(b), for MULT only.
  - HI gets bits [63:32], LO gets bits [31:0].
- DIV/DIVU:
  - Restoring division.
  - LO = quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - Divide by zero is not trapped: HI = a and LO = 0xFFFFFFFF, for both DIV and DIVU.
  - For DIV of 0x80000000 by -1: LO = 0x80000000, HI = 0.
- In FIX, hi and lo are both written at the clock edge.
- done=1 for exactly the cycle after FIX, i.e. the first IDLE cycle.
- start while busy=1 is ignored.
- hi_we/lo_we while busy=1 are ignored, and HI/LO keep their values until the FIX write.
- hi_we/lo_we in IDLE write wdata at the next edge.
- If start and hi_we/lo_we are asserted in the same IDLE cycle:
  - the MT write takes effect at that edge;
  - the operation still launches;
  - the FIX write later overwrites both HI and LO.
- If rst_n is asserted mid-operation, the operation is aborted immediately. The state returns to IDLE and the latched operands are discarded.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, count=0.
- Start accepted at edge E0 → busy=1 from E0 until edge E33.
  - CALC spans edges E1..E32.
  - FIX occurs at edge E33, which writes HI/LO.
  - After E33: busy=0 and done=1 for one cycle.
- Fixed latency is 33 cycles from the start edge to the HI/LO update, independent of operand values. There is no early termination.
- A new start is accepted in the done cycle itself, so back-to-back operations run at one every 34 cycles.
- hi and lo are registered outputs and can feed the result mux directly with no combinational path from inputs.

## Configuration
- Macro MDU_DIV_EN.
- Defined: full unit as above.
- Undefined:
  - The divide datapath is not compiled.
  - op 10/11 still run the 33-cycle sequence, but the FIX write leaves HI/LO unchanged. done still pulses.
  - MULT/MULTU are unaffected.

## Structure
- Shared package mdu_pkg holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - the state typedef (IDLE, CALC, FIX);
  - the iteration count constant ITER=32;
  - the divide-by-zero LO constant 0xFFFFFFFF.
- One sub-module is natural: mdu_div_step, the combinational single-iteration restoring divide step (remainder/quotient shift and subtract). It is instantiated only under MDU_DIV_EN.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → 33 cycles later HI=0xFFFFFFFE, LO=0x00000001, done pulses once, busy high for exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=-7, b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=0x80000000, b=-1 → LO=0x80000000, HI=0.
- DIVU a=5, b=0 → HI=5, LO=0xFFFFFFFF.
- MTHI 0x1234 in IDLE → HI=0x1234 next cycle.
- MTLO during busy → ignored.
- start during busy → ignored, with no change to the result or latency.
- rst_n pulsed low at CALC cycle 10 → hi=lo=0, busy=0 immediately.
- A new start after reset completes normally.
- With MDU_DIV_EN undefined: DIVU 100/7 → HI/LO unchanged and done pulses at cycle 34; MULTU 6×7 → LO=42.
